// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with a valid/ready handshake and a one-entry
// skid buffer. The skid register absorbs the beat accepted in the cycle in
// which downstream stalls. This keeps In_ready a pure function of registered
// state. Flush inserts a bubble. A saturating counter records stall cycles
// for hazard and performance debug.
module pipe_stage_buf #(
    parameter int                NUM_FIELDS = 4,
    parameter int                FIELD_W    = 32,
    parameter logic [FIELD_W-1:0] BUBBLE_VAL = '0,
    parameter int                CNT_W      = 16
) (
    input  logic                          Clk,
    input  logic                          Rst_n,
    input  logic                          Flush,
    input  logic                          In_valid,
    output logic                          In_ready,
    input  logic [NUM_FIELDS*FIELD_W-1:0] In_data,
    output logic                          Out_valid,
    input  logic                          Out_ready,
    output logic [NUM_FIELDS*FIELD_W-1:0] Out_data,
    input  logic                          Stall_clr,
    output logic [CNT_W-1:0]              Stall_cnt
);

    localparam int DATA_W = NUM_FIELDS * FIELD_W;

    // EMPTY: nothing held; FULL: main holds a beat; SKID: main and skid both hold beats
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] FULL  = 2'b01;
    localparam logic [1:0] SKID  = 2'b10;

    logic [1:0]        state_reg, state_next;
    logic [DATA_W-1:0] main_reg,  main_next;
    logic [DATA_W-1:0] skid_reg,  skid_next;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;
    logic [DATA_W-1:0] bubble_word;
    logic              in_fire;
    logic              out_fire;
    logic              stall;

    // Every field of an empty or flushed stage carries the bubble value
    generate
        for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_bubble
            assign bubble_word[gi*FIELD_W +: FIELD_W] = BUBBLE_VAL;
        end
    endgenerate

    // Outputs are decoded from registered state only
    assign Out_valid = (state_reg != EMPTY);
    assign In_ready  = (state_reg != SKID);
    assign Out_data  = main_reg;
    assign Stall_cnt = cnt_reg;

    assign in_fire  = In_valid & In_ready;
    assign out_fire = Out_valid & Out_ready;
    assign stall    = Out_valid & ~Out_ready;

    // Next-state and datapath selection. Flush overrides any handshake and
    // drops a beat offered in the same cycle.
    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (Flush) begin
            state_next = EMPTY;
            main_next  = bubble_word;
            skid_next  = bubble_word;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (in_fire) begin
                        state_next = FULL;
                        main_next  = In_data;
                    end
                end
                FULL: begin
                    if (in_fire && out_fire) begin
                        main_next = In_data;
                    end else if (in_fire) begin
                        state_next = SKID;
                        skid_next  = In_data;
                    end else if (out_fire) begin
                        state_next = EMPTY;
                        main_next  = bubble_word;
                    end
                end
                SKID: begin
                    if (out_fire) begin
                        state_next = FULL;
                        main_next  = skid_reg;
                        skid_next  = bubble_word;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    main_next  = bubble_word;
                    skid_next  = bubble_word;
                end
            endcase
        end
    end

    // Stall counter: a clear wins over an increment, and the count sticks at all-ones
    always_comb begin
        cnt_next = cnt_reg;
        if (Stall_clr) begin
            cnt_next = '0;
        end else if (stall && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    // State, data and counter registers with asynchronous reset to the empty stage
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg <= EMPTY;
            main_reg  <= bubble_word;
            skid_reg  <= bubble_word;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
            cnt_reg   <= cnt_next;
        end
    end

endmodule
